// File: rtl/ysyx_23060184_mem_stage.sv
// MEM stage: one load/store per instruction on a req/gnt/rvalid bus; YSYX_23060184_MISALIGN_TRAP_EN traps misaligned H/W.
// Latency 1 cycle (no memory op) or 3+ cycles (memory op); Mready low while busy, result held until Wready.
module ysyx_23060184_mem_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Evalid,
    output logic                  Mready,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  Mvalid,
    input  logic                  Wready,
    output logic [DATA_WIDTH-1:0] ALUResultM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  MisalignM
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_alu_result;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_wstrb;
    logic                  r_mem_we;
    logic [2:0]            r_funct3;
    logic                  r_misalign;

    logic                  w_accept;
    logic                  w_is_mem;
    logic                  w_is_byte;
    logic                  w_is_half;
    logic                  w_is_word;
    logic                  w_misalign;
    logic                  w_go_bus;
    logic [1:0]            w_off;
    logic [3:0]            w_wstrb;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_load;

    assign Mready   = (r_state == S_IDLE) | ((r_state == S_HOLD) & Wready);
    assign w_accept = Evalid & Mready;

    assign w_off     = ALUResult[1:0];
    assign w_is_mem  = MemRead | MemWrite;
    assign w_is_byte = (Funct3[1:0] == 2'b00);
    assign w_is_half = (Funct3[1:0] == 2'b01);
    assign w_is_word = Funct3[1];

`ifdef YSYX_23060184_MISALIGN_TRAP_EN
    assign w_misalign = w_is_mem & ((w_is_half & ALUResult[0]) | (w_is_word & (|ALUResult[1:0])));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_go_bus = w_is_mem & ~w_misalign;

    // Strobe shifts deliberately truncate to 4 lanes for misaligned halves.
    always_comb begin
        w_wstrb = 4'b1111;
        if (w_is_byte) begin
            w_wstrb = 4'b0001 << w_off;
        end else if (w_is_half) begin
            w_wstrb = 4'b0011 << w_off;
        end
    end

    assign w_wdata   = WriteData << {w_off, 3'b000};
    assign w_shifted = mem_rdata >> {ALUResultM[1:0], 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_funct3)
            3'b000:  w_load = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
            3'b001:  w_load = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_go_bus ? S_REQ : S_HOLD;
            S_REQ:  if (mem_gnt) w_state_nxt = S_WAIT;
            S_WAIT: if (mem_rvalid) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (w_accept) begin
                    w_state_nxt = w_go_bus ? S_REQ : S_HOLD;
                end else if (Wready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_alu_result <= '0;
            r_read_data  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= 4'b0000;
            r_mem_we     <= 1'b0;
            r_funct3     <= 3'b000;
            r_misalign   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_alu_result <= ALUResult;
                r_read_data  <= '0;
                r_funct3     <= Funct3;
                r_misalign   <= w_misalign;
                // A set MemWrite wins over MemRead, so the pair behaves as a store.
                if (w_go_bus) begin
                    r_mem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                    r_mem_we    <= MemWrite;
                    r_mem_wdata <= MemWrite ? w_wdata : '0;
                    r_mem_wstrb <= MemWrite ? w_wstrb : 4'b0000;
                end
            end
            if ((r_state == S_WAIT) && mem_rvalid && !r_mem_we) begin
                r_read_data <= w_load;
            end
        end
    end

    assign mem_req    = (r_state == S_REQ);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;
    assign Mvalid     = (r_state == S_HOLD);
    assign ALUResultM = r_alu_result;
    assign ReadDataM  = r_read_data;
    assign MisalignM  = r_misalign;

endmodule
